// File: rtl/dllp_tx_scheduler.sv
// PCIe DLL transmit scheduler: fixed-priority AXIS mux over Ack/Nak,
// replay, UpdateFC and new-TLP sources, plus replay and UpdateFC timers.
`timescale 1ns/1ps
module dllp_tx_scheduler #(
  parameter int DATA_WIDTH         = 32,
  parameter int KEEP_WIDTH         = DATA_WIDTH/8,
  parameter int USER_WIDTH         = 1,
  parameter int REPLAY_TIMER_LIMIT = 711,
  parameter int FC_UPDATE_LIMIT    = 7500
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [4*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [3:0]              s_axis_tvalid,
  input  logic [3:0]              s_axis_tlast,
  input  logic [4*USER_WIDTH-1:0] s_axis_tuser,
  output logic [3:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    m_axis_tready,
  input  logic                    outstanding_i,
  input  logic                    ack_progress_i,
  input  logic                    nak_i,
  input  logic                    replay_done_i,
  input  logic                    update_fc_i,
  output logic [3:0]              grant_o,
  output logic                    replay_active_o,
  output logic                    replay_req_o,
  output logic                    retrain_req_o,
  output logic                    fc_update_req_o
);

  localparam int RTW = $clog2(REPLAY_TIMER_LIMIT);
  localparam int FCW = $clog2(FC_UPDATE_LIMIT);
  localparam logic [RTW-1:0] RT_MAX = RTW'(REPLAY_TIMER_LIMIT - 1);
  localparam logic [FCW-1:0] FC_MAX = FCW'(FC_UPDATE_LIMIT - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [3:0]     grant_q, grant_d;
  logic [RTW-1:0] rt_cnt_q, rt_cnt_d;
  logic [1:0]     replay_num_q, replay_num_d;
  logic           replay_active_q, replay_active_d;
  logic           replay_req_q, replay_req_d;
  logic           retrain_q, retrain_d;
  logic [FCW-1:0] fc_cnt_q, fc_cnt_d;
  logic           fc_req_q, fc_req_d;

  logic [1:0] sel;
  logic       busy;
  logic [3:0] eligible;
  logic       last_hs;
  logic       src2_done;
  logic       expiry;
  logic       replay_start;
  logic [1:0] num_base;
  logic       fc_set;

  always_comb begin
    sel = 2'd0;
    unique case (1'b1)
      grant_q[1]: sel = 2'd1;
      grant_q[2]: sel = 2'd2;
      grant_q[3]: sel = 2'd3;
      default:    sel = 2'd0;
    endcase
  end

  assign busy = (state_q == GRANT);

  assign m_axis_tdata = busy ?
    s_axis_tdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_axis_tkeep = busy ?
    s_axis_tkeep[int'(sel)*KEEP_WIDTH +: KEEP_WIDTH] : '0;
  assign m_axis_tuser = busy ?
    s_axis_tuser[int'(sel)*USER_WIDTH +: USER_WIDTH] : '0;
  assign m_axis_tlast  = busy & s_axis_tlast[sel];
  assign m_axis_tvalid = |(grant_q & s_axis_tvalid);
  assign s_axis_tready = grant_q & {4{m_axis_tready}};

  assign last_hs   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign src2_done = last_hs & grant_q[2];

  // New TLPs stay parked while the retry buffer is being replayed
  assign eligible = s_axis_tvalid & {~replay_active_q, 3'b111};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (state_q == IDLE) begin
      if (|eligible) begin
        state_d = GRANT;
        grant_d = eligible & (~eligible + 4'd1);
      end
    end else if (last_hs) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end

  assign expiry = (rt_cnt_q == RT_MAX) & ~replay_active_q;
  assign replay_start = ~replay_active_q &
    ((expiry & ~ack_progress_i) | nak_i);
  assign num_base = ack_progress_i ? 2'd0 : replay_num_q;

  always_comb begin
    rt_cnt_d = rt_cnt_q;
    if (ack_progress_i | ~outstanding_i | replay_start)
      rt_cnt_d = '0;
    else if (~replay_active_q & ~grant_q[1])
      rt_cnt_d = rt_cnt_q + RTW'(1);

    replay_num_d = replay_start ? num_base + 2'd1 : num_base;
    retrain_d    = replay_start & (num_base == 2'd3);
    replay_req_d = replay_start;

    replay_active_d = replay_active_q;
    if (replay_start)
      replay_active_d = 1'b1;
    else if (replay_done_i)
      replay_active_d = 1'b0;
  end

  // Timer-driven set fires once per period; a pending request is not re-set
  assign fc_set = update_fc_i | ((fc_cnt_q == FC_MAX) & ~fc_req_q);

  always_comb begin
    fc_req_d = fc_set | (fc_req_q & ~src2_done);
    fc_cnt_d = fc_cnt_q;
    if (src2_done)
      fc_cnt_d = '0;
    else if (fc_cnt_q != FC_MAX)
      fc_cnt_d = fc_cnt_q + FCW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      rt_cnt_q        <= '0;
      replay_num_q    <= '0;
      replay_active_q <= 1'b0;
      replay_req_q    <= 1'b0;
      retrain_q       <= 1'b0;
      fc_cnt_q        <= '0;
      fc_req_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      rt_cnt_q        <= rt_cnt_d;
      replay_num_q    <= replay_num_d;
      replay_active_q <= replay_active_d;
      replay_req_q    <= replay_req_d;
      retrain_q       <= retrain_d;
      fc_cnt_q        <= fc_cnt_d;
      fc_req_q        <= fc_req_d;
    end
  end

  assign grant_o         = grant_q;
  assign replay_active_o = replay_active_q;
  assign replay_req_o    = replay_req_q;
  assign retrain_req_o   = retrain_q;
  assign fc_update_req_o = fc_req_q;

endmodule

// File: tb/tb_dllp_tx_scheduler.sv
// Scenario bench for dllp_tx_scheduler: scoreboard of output beats plus
// per-scenario timing checks on grant, replay and UpdateFC outputs.
`timescale 1ns/1ps
module tb_dllp_tx_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tlast;
  logic [3:0]   s_tuser;
  logic [3:0]   s_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic [0:0]   m_tuser;
  logic         m_tready;
  logic         outstanding_i;
  logic         ack_progress_i;
  logic         nak_i;
  logic         replay_done_i;
  logic         update_fc_i;
  logic [3:0]   grant_o;
  logic         replay_active_o;
  logic         replay_req_o;
  logic         retrain_req_o;
  logic         fc_update_req_o;

  dllp_tx_scheduler #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(1),
    .REPLAY_TIMER_LIMIT(16), .FC_UPDATE_LIMIT(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .outstanding_i(outstanding_i), .ack_progress_i(ack_progress_i),
    .nak_i(nak_i), .replay_done_i(replay_done_i),
    .update_fc_i(update_fc_i), .grant_o(grant_o),
    .replay_active_o(replay_active_o), .replay_req_o(replay_req_o),
    .retrain_req_o(retrain_req_o), .fc_update_req_o(fc_update_req_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    tog_en;

  function automatic beat_t mk(input int s, input int b, input int n,
                               input logic [31:0] base);
    beat_t e;
    e.d = base + 32'(b);
    e.k = 4'(1 << s);
    e.l = (b == n - 1);
    e.u = s[0];
    return e;
  endfunction

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_pkt(input int s, input int n, input logic [31:0] base);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(s, b, n, base));
  endtask

  task automatic clear_inputs();
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b1; outstanding_i = 1'b0; ack_progress_i = 1'b0;
    nak_i = 1'b0; replay_done_i = 1'b0; update_fc_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    clear_inputs();
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  task automatic drive_pkt(input int s, input int n, input logic [31:0] base);
    beat_t e;
    int w;
    for (int b = 0; b < n; b++) begin
      e = mk(s, b, n, base);
      s_tdata[s*32 +: 32] = e.d;
      s_tkeep[s*4 +: 4]   = e.k;
      s_tlast[s]          = e.l;
      s_tuser[s]          = e.u;
      s_tvalid[s]         = 1'b1;
      w = 0;
      do begin
        @(negedge clk_i);
        w++;
      end while (!s_tready[s] && w < 200);
      if (!s_tready[s]) begin
        n_cmp++; n_err++;
        $display("FAIL drv_timeout src=%0d beat=%0d got no tready", s, b);
        break;
      end
      sync();
    end
    s_tvalid[s] = 1'b0;
    s_tlast[s]  = 1'b0;
  endtask

  task automatic monitor();
    beat_t e, got;
    forever begin
      @(negedge clk_i);
      if (rst_i && m_tvalid && m_tready) begin
        got = {m_tdata, m_tkeep, m_tlast, m_tuser};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected got=%h want=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL sb_beat got=%h want=%h", got, e);
          end
        end
      end
    end
  endtask

  task automatic wait_req(output bit ok, output bit retr);
    ok = 0;
    retr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (replay_req_o) begin
        ok = 1;
        retr = retrain_req_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    clear_inputs();
    s_tvalid = 4'hF; s_tlast = 4'hF; s_tdata = {4{32'hDEADBEEF}};
    nak_i = 1'b1; update_fc_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({grant_o, s_tready} !== 8'h00) begin
      n_err++;
      $display("FAIL rst_grant_ready got=%h want=00", {grant_o, s_tready});
    end
    n_cmp++;
    if ({m_tvalid, m_tdata} !== 33'h0) begin
      n_err++;
      $display("FAIL rst_mout got=%h want=0", {m_tvalid, m_tdata});
    end
    n_cmp++;
    if ({replay_active_o, replay_req_o, retrain_req_o, fc_update_req_o}
        !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_flags got=%b want=0000",
        {replay_active_o, replay_req_o, retrain_req_o, fc_update_req_o});
    end
    do_reset();
    m_tready = 1'b0;
    s_tdata[96 +: 32] = 32'h33330000; s_tkeep[12 +: 4] = 4'h8;
    s_tlast[3] = 1'b0; s_tvalid[3] = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({grant_o, m_tvalid} !== 5'b1000_1) begin
      n_err++;
      $display("FAIL midpkt_grant got=%b want=10001", {grant_o, m_tvalid});
    end
    #2 rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({grant_o, m_tvalid, s_tready} !== 9'h0) begin
      n_err++;
      $display("FAIL midpkt_drop got=%b want=0",
        {grant_o, m_tvalid, s_tready});
    end
    do_reset();
  endtask

  task automatic test_priority();
    logic [3:0] g[5];
    logic [3:0] eg[5];
    logic       tr3;
    eg = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    tr3 = 1'b1;
    sync();
    push_pkt(0, 1, 32'h100);
    push_pkt(3, 1, 32'h300);
    fork
      drive_pkt(0, 1, 32'h100);
      drive_pkt(3, 1, 32'h300);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk_i);
        g[i] = grant_o;
        if (i == 1) tr3 = s_tready[3];
      end
    join
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (g[i] !== eg[i]) begin
        n_err++;
        $display("FAIL prio_grant[%0d] got=%b want=%b", i, g[i], eg[i]);
      end
    end
    n_cmp++;
    if (tr3 !== 1'b0) begin
      n_err++;
      $display("FAIL prio_tready3 got=%b want=0", tr3);
    end
    sync();
  endtask

  task automatic test_backpressure();
    logic [3:0] g1, g2;
    bit found;
    sync();
    push_pkt(3, 4, 32'h3A0);
    push_pkt(0, 1, 32'h0B0);
    tog_en = 1;
    fork
      begin
        drive_pkt(3, 4, 32'h3A0);
        tog_en = 0;
      end
      begin
        while (tog_en) begin
          sync();
          if (tog_en) m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
      begin
        repeat (3) @(posedge clk_i);
        #1;
        drive_pkt(0, 1, 32'h0B0);
      end
      begin
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
          @(negedge clk_i);
          if (grant_o == 4'b1000 && m_tvalid && m_tready && m_tlast)
            found = 1;
        end
        @(negedge clk_i); g1 = grant_o;
        @(negedge clk_i); g2 = grant_o;
        n_cmp++;
        if (!found || g1 !== 4'b0000 || g2 !== 4'b0001) begin
          n_err++;
          $display("FAIL bp_handover got=%b/%b/%b want=1/0000/0001",
            found, g1, g2);
        end
      end
    join
    sync();
  endtask

  task automatic test_replay_timeout();
    int first, pulses;
    bit blocked_bad;
    logic retr;
    do_reset();
    outstanding_i = 1'b1;
    first = 0; pulses = 0; retr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (replay_req_o) begin
        pulses++;
        if (first == 0) begin
          first = k;
          retr = retrain_req_o;
        end
      end
    end
    n_cmp++;
    if (first != 16 || pulses != 1) begin
      n_err++;
      $display("FAIL rt_expiry got=cyc%0d x%0d want=cyc16 x1", first, pulses);
    end
    n_cmp++;
    if ({replay_active_o, retr} !== 2'b10) begin
      n_err++;
      $display("FAIL rt_active got=%b want=10", {replay_active_o, retr});
    end
    sync();
    push_pkt(3, 1, 32'h3C0);
    blocked_bad = 0;
    fork
      drive_pkt(3, 1, 32'h3C0);
      begin
        repeat (4) begin
          @(negedge clk_i);
          if (grant_o != 4'b0000 || m_tvalid) blocked_bad = 1;
        end
        n_cmp++;
        if (blocked_bad) begin
          n_err++;
          $display("FAIL rt_block3 got=granted want=blocked");
        end
        sync();
        replay_done_i = 1'b1;
        sync();
        replay_done_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (replay_active_o !== 1'b0) begin
          n_err++;
          $display("FAIL rt_done got=%b want=0", replay_active_o);
        end
      end
    join
    outstanding_i = 1'b0;
    sync();
  endtask

  task automatic test_rollover();
    bit ok, retr;
    do_reset();
    outstanding_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        ack_progress_i = 1'b1;
        sync();
        ack_progress_i = 1'b0;
      end
      wait_req(ok, retr);
      n_cmp++;
      if (!ok || retr !== (i == 3)) begin
        n_err++;
        $display("FAIL roll[%0d] got=req%0b retrain%0b want=req1 retrain%0b",
          i, ok, retr, (i == 3));
      end
      sync();
      replay_done_i = 1'b1;
      sync();
      replay_done_i = 1'b0;
    end
    outstanding_i = 1'b0;
    sync();
  endtask

  task automatic test_simultaneous();
    int pulses;
    do_reset();
    outstanding_i = 1'b1;
    repeat (15) @(posedge clk_i);
    #1 nak_i = 1'b1;
    sync();
    nak_i = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (replay_req_o) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || !replay_active_o) begin
      n_err++;
      $display("FAIL sim_nak_exp got=x%0d act%0b want=x1 act1",
        pulses, replay_active_o);
    end
    do_reset();
    outstanding_i = 1'b1;
    repeat (15) @(posedge clk_i);
    #1 ack_progress_i = 1'b1;
    sync();
    ack_progress_i = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (replay_req_o) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || replay_active_o) begin
      n_err++;
      $display("FAIL sim_ack_exp got=x%0d act%0b want=x0 act0",
        pulses, replay_active_o);
    end
    outstanding_i = 1'b0;
    sync();
  endtask

  task automatic test_nak();
    int pulses;
    do_reset();
    nak_i = 1'b1;
    sync();
    nak_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({replay_req_o, replay_active_o} !== 2'b11) begin
      n_err++;
      $display("FAIL nak_start got=%b want=11", {replay_req_o, replay_active_o});
    end
    sync();
    nak_i = 1'b1;
    sync();
    nak_i = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (replay_req_o) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL nak_ignored got=x%0d want=x0", pulses);
    end
    sync();
    nak_i = 1'b1; replay_done_i = 1'b1;
    sync();
    nak_i = 1'b0; replay_done_i = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (replay_req_o) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || replay_active_o) begin
      n_err++;
      $display("FAIL nak_done got=x%0d act%0b want=x0 act0",
        pulses, replay_active_o);
    end
    sync();
  endtask

  task automatic fc_clear_pkt(input logic [31:0] base);
    bit found;
    push_pkt(2, 2, base);
    fork
      drive_pkt(2, 2, base);
      begin
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
          @(negedge clk_i);
          if (grant_o[2] && m_tvalid && m_tready && m_tlast) found = 1;
        end
        @(negedge clk_i);
        n_cmp++;
        if (!found || fc_update_req_o !== 1'b0) begin
          n_err++;
          $display("FAIL fc_clear got=seen%0b req%0b want=seen1 req0",
            found, fc_update_req_o);
        end
      end
    join
    sync();
  endtask

  task automatic test_fc();
    int first;
    do_reset();
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (fc_update_req_o && first == 0) first = k;
    end
    n_cmp++;
    if (first != 32 || !fc_update_req_o) begin
      n_err++;
      $display("FAIL fc_period got=cyc%0d lvl%0b want=cyc32 lvl1",
        first, fc_update_req_o);
    end
    sync();
    fc_clear_pkt(32'h2D0);
    repeat (5) sync();
    @(negedge clk_i);
    n_cmp++;
    if (fc_update_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL fc_idle got=%b want=0", fc_update_req_o);
    end
    sync();
    update_fc_i = 1'b1;
    sync();
    update_fc_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (fc_update_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL fc_immediate got=%b want=1", fc_update_req_o);
    end
    sync();
    fc_clear_pkt(32'h2E0);
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b0;
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_priority();
    test_backpressure();
    test_replay_timeout();
    test_rollover();
    test_simultaneous();
    test_nak();
    test_fc();
    repeat (3) sync();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
